jk_down_counter_reload: RTL and testbench
=========================================

JK_DOWN_COUNTER_RELOAD -- requirements
Module: jk_down_counter_reload

Interface
REQ-001 The block SHALL have parameter W, default 3, giving the counter width in bits (W >= 2).
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port CLR, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port START, input, 1 bit: synchronous load-and-run request, sampled on the rising clk edge.
REQ-005 Port STOP, input, 1 bit: synchronous halt request, sampled on the rising clk edge.
REQ-006 Port MODE, input, 1 bit: 0 selects one-shot and 1 selects periodic; sampled only with an accepted START.
REQ-007 Port LOAD_value, input, W bits: start/reload value, sampled only with an accepted START.
REQ-008 Port count, output, W bits: current registered count.
REQ-009 Port busy, output, 1 bit: high while the state is RUN.
REQ-010 Port TC, output, 1 bit: registered terminal-count pulse, one cycle wide.

Function
REQ-011 The block SHALL implement two states, IDLE and RUN, plus internal registers reload_reg (W bits) and mode_reg (1 bit).
REQ-012 Input priority per edge SHALL be STOP > START > counting.
REQ-013 In IDLE with START=1 and LOAD_value!=0: count<=LOAD_value, reload_reg<=LOAD_value, mode_reg<=MODE, state<=RUN, TC<=0.
REQ-014 In IDLE with START=1 and LOAD_value==0: count<=0, TC<=1 for one cycle, state stays IDLE, in either MODE.
REQ-015 In IDLE without START: count holds its value and TC<=0.
REQ-016 In RUN with count>1 and no STOP/START: count<=count-1 and TC<=0.
REQ-017 In RUN with count==1 and mode_reg==0: count<=0, TC<=1, state<=IDLE.
REQ-018 In RUN with count==1 and mode_reg==1: count<=reload_reg, TC<=1, state stays RUN.
REQ-019 The TC period in periodic mode SHALL be exactly reload_reg cycles; in that mode count never shows 0.
REQ-020 In RUN with STOP=1: state<=IDLE, count holds, TC<=0, even if count==1 that edge.
REQ-021 In RUN with START=1 and STOP=0: restart per REQ-013/REQ-014 with the new LOAD_value and MODE; no TC for the aborted run.
REQ-022 STOP in IDLE SHALL have no effect.
REQ-023 count SHALL never decrement below 0; there is no underflow wrap.
REQ-024 busy SHALL equal (state==RUN), and TC SHALL be driven only from a register.
REQ-025 Latency: TC SHALL rise on the same edge on which count transitions from 1 to 0 (or to reload_reg); a one-shot run of N takes N edges after the START edge.

Reset
REQ-026 When CLR=0, the block SHALL immediately force count=0, TC=0, busy=0, state=IDLE, reload_reg=0 and mode_reg=0, independent of clk.
REQ-027 While CLR=0, all synchronous inputs SHALL be ignored.
REQ-028 Operation SHALL resume on the first rising clk edge after CLR returns to 1.
REQ-029 CLR asserted mid-run SHALL produce no TC pulse.
REQ-030 No output SHALL ever be X or Z after reset.

Verification
REQ-031 One-shot: W=3, START with LOAD_value=5, MODE=0 -> count 5,4,3,2,1,0 on consecutive edges; TC high only in the cycle where count=0; busy falls on that same edge.
REQ-032 Periodic: START with LOAD_value=3, MODE=1 -> count 3,2,1,3,2,1,... and TC high every 3rd cycle; busy stays 1.
REQ-033 STOP: STOP=1 while count=2 -> count holds 2, busy=0, no TC; a later START with LOAD_value=4 restarts from 4.
REQ-034 Simultaneous STOP and START at count=1 -> STOP wins: IDLE, count=1, TC=0.
REQ-035 Zero load: START with LOAD_value=0 -> single TC pulse, count=0, busy stays 0.
REQ-036 Asynchronous reset: CLR low mid-clock while count=4 in RUN -> count=0, busy=0 and TC=0 with no clk edge; counting stays idle after release until the next START.

Source files
------------

// File: rtl/jk_down_counter_reload_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : jk_down_counter_reload_if
// Brief    : Control/status bundle for the reloadable down counter.
// Revision : 1.0
//------------------------------------------------------------------------------
interface jk_down_counter_reload_if #(
  parameter int W = 3
) ();

  logic         START;
  logic         STOP;
  logic         MODE;
  logic [W-1:0] LOAD_value;
  logic [W-1:0] count;
  logic         busy;
  logic         TC;

  modport master (
    output START,
    output STOP,
    output MODE,
    output LOAD_value,
    input  count,
    input  busy,
    input  TC
  );

  modport slave (
    input  START,
    input  STOP,
    input  MODE,
    input  LOAD_value,
    output count,
    output busy,
    output TC
  );

endinterface : jk_down_counter_reload_if
`default_nettype wire

// File: rtl/jk_down_counter_reload.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : jk_down_counter_reload
// Brief    : Down counter with one-shot/periodic reload and registered TC pulse.
// Revision : 1.0
//------------------------------------------------------------------------------
module jk_down_counter_reload #(
  parameter int W = 3
) (
  input  wire logic                    clk,
  input  wire logic                    CLR,
  jk_down_counter_reload_if.slave      bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [W-1:0] c_one = {{(W-1){1'b0}}, 1'b1};

  state_t       r_state;
  logic [W-1:0] r_count;
  logic [W-1:0] r_reload;
  logic         r_mode;
  logic         r_tc;

  // STOP outranks START, which outranks counting. A zero load is a
  // degenerate run: it terminates on the loading edge and never enters RUN.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_mode   <= 1'b0;
      r_tc     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.START) begin
            if (bus.LOAD_value != '0) begin
              r_count  <= bus.LOAD_value;
              r_reload <= bus.LOAD_value;
              r_mode   <= bus.MODE;
              r_state  <= RUN;
              r_tc     <= 1'b0;
            end else begin
              r_count  <= '0;
              r_tc     <= 1'b1;
            end
          end else begin
            r_tc <= 1'b0;
          end
        end

        RUN: begin
          if (bus.STOP) begin
            r_state <= IDLE;
            r_tc    <= 1'b0;
          end else if (bus.START) begin
            if (bus.LOAD_value != '0) begin
              r_count  <= bus.LOAD_value;
              r_reload <= bus.LOAD_value;
              r_mode   <= bus.MODE;
              r_tc     <= 1'b0;
            end else begin
              r_count  <= '0;
              r_state  <= IDLE;
              r_tc     <= 1'b1;
            end
          end else if (r_count > c_one) begin
            r_count <= r_count - c_one;
            r_tc    <= 1'b0;
          end else if (r_count == c_one) begin
            r_tc <= 1'b1;
            if (r_mode) begin
              r_count <= r_reload;
            end else begin
              r_count <= '0;
              r_state <= IDLE;
            end
          end else begin
            // Unreachable with a nonzero load; fall back to IDLE without wrapping.
            r_state <= IDLE;
            r_tc    <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_tc    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count = r_count;
  assign bus.busy  = (r_state == RUN);
  assign bus.TC    = r_tc;

endmodule : jk_down_counter_reload
`default_nettype wire

// File: tb/tb_jk_down_counter_reload.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_jk_down_counter_reload
// Brief    : Scoreboard bench for jk_down_counter_reload (W=3).
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_jk_down_counter_reload;

  localparam int W = 3;

  typedef struct packed {
    logic         start;
    logic         stop;
    logic         mode;
    logic [W-1:0] load;
    logic [W-1:0] c;
    logic         b;
    logic         t;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] c;
    logic         b;
    logic         t;
  } exp_t;

  logic clk;
  logic CLR;
  int   n_vec;
  int   n_bad;
  exp_t sb[$];

  jk_down_counter_reload_if #(.W(W)) bus ();

  jk_down_counter_reload #(.W(W)) dut (
    .clk (clk),
    .CLR (CLR),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic sp, input logic md,
                              input int ld, input int c, input logic b, input logic t);
    vec_t v;
    v.start = st;
    v.stop  = sp;
    v.mode  = md;
    v.load  = ld[W-1:0];
    v.c     = c[W-1:0];
    v.b     = b;
    v.t     = t;
    return v;
  endfunction

  // Drive one vector at the falling edge, queue its expected result,
  // and return just after the following rising edge.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    bus.START      = v.start;
    bus.STOP       = v.stop;
    bus.MODE       = v.mode;
    bus.LOAD_value = v.load;
    e.c = v.c;
    e.b = v.b;
    e.t = v.t;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    vec_t v;
    CLR = 1'b1;
    #1;
    CLR = 1'b0;
    #1;
    e = '{c: '0, b: 1'b0, t: 1'b0};
    sb.push_back(e);
    e = sb.pop_front();
    n_vec++;
    if ({bus.count, bus.busy, bus.TC} !== {e.c, e.b, e.t}) begin
      n_bad++;
      $display("FAIL reset_state: got count=%0d busy=%b TC=%b, want count=%0d busy=%b TC=%b",
               bus.count, bus.busy, bus.TC, e.c, e.b, e.t);
    end
    // Inputs must be ignored while CLR is held low.
    v = mk(1, 0, 1, 5, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      apply(v);
      e = sb.pop_front();
      n_vec++;
      if ({bus.count, bus.busy, bus.TC} !== {e.c, e.b, e.t}) begin
        n_bad++;
        $display("FAIL reset_hold[%0d]: got count=%0d busy=%b TC=%b, want count=%0d busy=%b TC=%b",
                 i, bus.count, bus.busy, bus.TC, e.c, e.b, e.t);
      end
    end
    @(negedge clk);
    bus.START = 1'b0;
    CLR = 1'b1;
  endtask

  task automatic test_oneshot();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 0, 0, 5, 5, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 4, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 3, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 2, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({bus.count, bus.busy, bus.TC} !== {e.c, e.b, e.t}) begin
        n_bad++;
        $display("FAIL oneshot[%0d]: got count=%0d busy=%b TC=%b, want count=%0d busy=%b TC=%b",
                 i, bus.count, bus.busy, bus.TC, e.c, e.b, e.t);
      end
    end
  endtask

  task automatic test_periodic();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 0, 1, 3, 3, 1, 0));
    for (int k = 0; k < 3; k++) begin
      v.push_back(mk(0, 0, 0, 0, 2, 1, 0));
      v.push_back(mk(0, 0, 0, 0, 1, 1, 0));
      v.push_back(mk(0, 0, 0, 0, 3, 1, 1));
    end
    v.push_back(mk(1, 0, 1, 7, 7, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 6, 1, 0));
    foreach (v[i]) begin
      apply(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({bus.count, bus.busy, bus.TC} !== {e.c, e.b, e.t}) begin
        n_bad++;
        $display("FAIL periodic[%0d]: got count=%0d busy=%b TC=%b, want count=%0d busy=%b TC=%b",
                 i, bus.count, bus.busy, bus.TC, e.c, e.b, e.t);
      end
    end
  endtask

  task automatic test_stop();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 0, 1, 3, 3, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 2, 1, 0));
    v.push_back(mk(0, 1, 0, 0, 2, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 2, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 2, 0, 0));
    v.push_back(mk(1, 0, 0, 4, 4, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 3, 1, 0));
    v.push_back(mk(1, 0, 0, 2, 2, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 1, 0));
    v.push_back(mk(0, 1, 0, 0, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({bus.count, bus.busy, bus.TC} !== {e.c, e.b, e.t}) begin
        n_bad++;
        $display("FAIL stop[%0d]: got count=%0d busy=%b TC=%b, want count=%0d busy=%b TC=%b",
                 i, bus.count, bus.busy, bus.TC, e.c, e.b, e.t);
      end
    end
  endtask

  task automatic test_stop_start_tie();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 0, 0, 4, 4, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 3, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 2, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 1, 0));
    v.push_back(mk(1, 1, 1, 6, 1, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({bus.count, bus.busy, bus.TC} !== {e.c, e.b, e.t}) begin
        n_bad++;
        $display("FAIL tie[%0d]: got count=%0d busy=%b TC=%b, want count=%0d busy=%b TC=%b",
                 i, bus.count, bus.busy, bus.TC, e.c, e.b, e.t);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 0, 0, 7, 7, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 6, 1, 0));
    v.push_back(mk(1, 0, 1, 2, 2, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 2, 1, 1));
    v.push_back(mk(0, 0, 0, 0, 1, 1, 0));
    v.push_back(mk(1, 0, 1, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({bus.count, bus.busy, bus.TC} !== {e.c, e.b, e.t}) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got count=%0d busy=%b TC=%b, want count=%0d busy=%b TC=%b",
                 i, bus.count, bus.busy, bus.TC, e.c, e.b, e.t);
      end
    end
  endtask

  task automatic test_zero_load();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 0, 0, 3, 3, 1, 0));
    v.push_back(mk(0, 1, 0, 0, 3, 0, 0));
    v.push_back(mk(1, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 0, 1, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({bus.count, bus.busy, bus.TC} !== {e.c, e.b, e.t}) begin
        n_bad++;
        $display("FAIL zero_load[%0d]: got count=%0d busy=%b TC=%b, want count=%0d busy=%b TC=%b",
                 i, bus.count, bus.busy, bus.TC, e.c, e.b, e.t);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t v[$];
    exp_t e;
    v.push_back(mk(1, 0, 1, 6, 6, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 5, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 4, 1, 0));
    foreach (v[i]) begin
      apply(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({bus.count, bus.busy, bus.TC} !== {e.c, e.b, e.t}) begin
        n_bad++;
        $display("FAIL async_pre[%0d]: got count=%0d busy=%b TC=%b, want count=%0d busy=%b TC=%b",
                 i, bus.count, bus.busy, bus.TC, e.c, e.b, e.t);
      end
    end
    // Mid-cycle, well away from either clock edge.
    #2;
    CLR = 1'b0;
    #1;
    e = '{c: '0, b: 1'b0, t: 1'b0};
    sb.push_back(e);
    e = sb.pop_front();
    n_vec++;
    if ({bus.count, bus.busy, bus.TC} !== {e.c, e.b, e.t}) begin
      n_bad++;
      $display("FAIL async_clear: got count=%0d busy=%b TC=%b, want count=%0d busy=%b TC=%b",
               bus.count, bus.busy, bus.TC, e.c, e.b, e.t);
    end
    @(negedge clk);
    CLR = 1'b1;
    v.delete();
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 0, 0, 2, 2, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 1, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    foreach (v[i]) begin
      apply(v[i]);
      e = sb.pop_front();
      n_vec++;
      if ({bus.count, bus.busy, bus.TC} !== {e.c, e.b, e.t}) begin
        n_bad++;
        $display("FAIL async_post[%0d]: got count=%0d busy=%b TC=%b, want count=%0d busy=%b TC=%b",
                 i, bus.count, bus.busy, bus.TC, e.c, e.b, e.t);
      end
    end
  endtask

  initial begin
    n_vec          = 0;
    n_bad          = 0;
    CLR            = 1'b1;
    bus.START      = 1'b0;
    bus.STOP       = 1'b0;
    bus.MODE       = 1'b0;
    bus.LOAD_value = '0;

    test_reset();
    test_oneshot();
    test_periodic();
    test_stop();
    test_stop_start_tie();
    test_back_to_back();
    test_zero_load();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_jk_down_counter_reload
`default_nettype wire
